instr_fetch: RTL and testbench

- Instruction fetch stage. Generates the PC, issues word reads on the instruction bus, and buffers the returned instructions together with their PCs.
- Presents instructions to the decode stage through a valid/ready handshake.
- Accepts redirects for branches, JAL, JALR and traps from downstream. A redirect flushes all in-flight fetches.

---
 rtl/instr_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Generates the fetch PC, issues word reads on the
// instruction bus, buffers returned words together with their PCs and hands
// them to decode over a valid/ready handshake. A redirect (branch, JAL, JALR,
// trap) flushes the buffer and causes every still-outstanding read to be
// dropped when its response comes back.
//
// Optional feature macro: INSTR_FETCH_MISALIGN_EXC_EN
//   defined   : a redirect to a PC with [1:0] != 0 issues no fetch; instead a
//               single {redirect_pc, NOP} entry flagged exc_instr_misalign is
//               queued and fetching halts until the next redirect.
//   undefined : redirect_pc[1:0] is forced to 0, exc_instr_misalign is tied 0.
//
// Ports
//   clk                 in   core clock
//   rst_b               in   asynchronous active-low reset
//   ibus_req            out  read request valid
//   ibus_addr[31:0]     out  word-aligned read address
//   ibus_ready          in   request accepted when ibus_req && ibus_ready
//   ibus_rvalid         in   read data valid, responses return in order
//   ibus_rdata[31:0]    in   instruction word
//   redirect_valid      in   flush and refetch
//   redirect_pc[31:0]   in   new fetch PC
//   if_valid            out  instruction available to decode
//   if_instr[31:0]      out  instruction to decoder (NOP when empty)
//   if_pc[31:0]         out  PC of if_instr (holds last value when empty)
//   id_ready            in   decode consumes when if_valid && id_ready
//   exc_instr_misalign  out  misaligned-target flag travelling with if_instr
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        exc_instr_misalign
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]  DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]  NOP     = 32'h0000_0013;

  // State
  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] discard_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] tag_rd_ptr_reg;
  logic [PW-1:0] tag_wr_ptr_reg;
  logic [31:0]   last_pc_reg;

  // Instruction buffer and the parallel FIFO of issued addresses
  logic [31:0] buf_pc_mem    [FIFO_DEPTH];
  logic [31:0] buf_instr_mem [FIFO_DEPTH];
  logic [31:0] tag_mem       [FIFO_DEPTH];

  // Combinational
  logic        reserve_ok;
  logic        issue_hs;
  logic        fifo_empty;
  logic        pop;
  logic        push_rsp;
  logic        mis_redirect;
  logic        halted;
  logic [31:0] target_pc;
  logic        buf_we;
  logic [PW-1:0] buf_waddr;
  logic [31:0] buf_wpc;
  logic [31:0] buf_winstr;

`ifdef INSTR_FETCH_MISALIGN_EXC_EN
  logic buf_exc_mem [FIFO_DEPTH];
  logic halt_reg;
  logic buf_wexc;

  assign mis_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target_pc    = redirect_pc;
  assign halted       = halt_reg;
`else
  assign mis_redirect = 1'b0;
  assign target_pc    = redirect_pc & 32'hFFFF_FFFC;
  assign halted       = 1'b0;
`endif

  // Reservation counts both reads in flight (including ones that will be
  // discarded) and buffered entries, so a response always has a free slot.
  // The entry popped this cycle is still counted.
  assign reserve_ok = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < DEPTH_W;
  assign ibus_req   = rst_b && !redirect_valid && !halted && reserve_ok;
  assign ibus_addr  = fetch_pc_reg;
  assign issue_hs   = ibus_req && ibus_ready;

  assign fifo_empty = (count_reg == '0);
  assign if_valid   = !fifo_empty;
  assign if_instr   = fifo_empty ? NOP : buf_instr_mem[rd_ptr_reg];
  assign if_pc      = fifo_empty ? last_pc_reg : buf_pc_mem[rd_ptr_reg];

  // A redirect wins over both a pop and a response in the same cycle.
  assign pop      = if_valid && id_ready && !redirect_valid;
  assign push_rsp = ibus_rvalid && !redirect_valid && (discard_reg == '0);

  always_comb begin
    buf_we     = 1'b0;
    buf_waddr  = wr_ptr_reg;
    buf_wpc    = tag_mem[tag_rd_ptr_reg];
    buf_winstr = ibus_rdata;
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
    buf_wexc   = 1'b0;
`endif
    if (mis_redirect) begin
      // Buffer is cleared this cycle, so the exception entry lands in slot 0.
      buf_we     = 1'b1;
      buf_waddr  = '0;
      buf_wpc    = redirect_pc;
      buf_winstr = NOP;
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
      buf_wexc   = 1'b1;
`endif
    end else if (push_rsp) begin
      buf_we = 1'b1;
    end
  end

`ifdef INSTR_FETCH_MISALIGN_EXC_EN
  assign exc_instr_misalign = !fifo_empty && buf_exc_mem[rd_ptr_reg];
`else
  assign exc_instr_misalign = 1'b0;
`endif

  // Control state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc_reg    <= RESET_VECTOR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      tag_rd_ptr_reg  <= '0;
      tag_wr_ptr_reg  <= '0;
      last_pc_reg     <= '0;
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
      halt_reg        <= 1'b0;
`endif
    end else begin
      outstanding_reg <= outstanding_reg + CW'(issue_hs) - CW'(ibus_rvalid);

      // Every response retires one issued address, discarded or not.
      if (issue_hs)    tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(1);
      if (ibus_rvalid) tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(1);

      // Remember the presented PC so if_pc can hold it once the buffer drains.
      if (!fifo_empty) last_pc_reg <= buf_pc_mem[rd_ptr_reg];

      if (redirect_valid) begin
        fetch_pc_reg <= target_pc;
        // Everything still in flight is stale; the response arriving now is
        // already being dropped. Prior discard is included in outstanding.
        discard_reg  <= outstanding_reg - CW'(ibus_rvalid);
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= PW'(mis_redirect);
        count_reg    <= CW'(mis_redirect);
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
        halt_reg     <= mis_redirect;
`endif
      end else begin
        if (issue_hs) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (ibus_rvalid && (discard_reg != '0)) discard_reg <= discard_reg - CW'(1);
        if (push_rsp) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)      rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + CW'(push_rsp) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (issue_hs) tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_pc_mem[buf_waddr]    <= buf_wpc;
      buf_instr_mem[buf_waddr] <= buf_winstr;
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
      buf_exc_mem[buf_waddr]   <= buf_wexc;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. An in-order bus model returns a word derived from the
// address after a programmable latency. The reference model is the program
// order view: the bus must see addresses in sequence from the last redirect
// target, and decode must see exactly that sequence of PCs with matching words,
// with nothing stale, skipped or repeated.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        exc_instr_misalign;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_b              (rst_b),
    .ibus_req           (ibus_req),
    .ibus_addr          (ibus_addr),
    .ibus_ready         (ibus_ready),
    .ibus_rvalid        (ibus_rvalid),
    .ibus_rdata         (ibus_rdata),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .if_valid           (if_valid),
    .if_instr           (if_instr),
    .if_pc              (if_pc),
    .id_ready           (id_ready),
    .exc_instr_misalign (exc_instr_misalign)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        bq[$];
  int          cyc;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_pc;
  logic        exp_exc;
  bit          halted;
  int          hs_count;
  int          pop_count;
  int          total_pops = 0;
  logic [31:0] hs_log[$];
  bit          first_pending;
  logic [31:0] first_pop_pc;
  logic [31:0] first_pop_instr;
  logic        first_pop_exc;
  logic        obs_req, obs_valid, obs_rvalid;
  logic [31:0] obs_pc, obs_addr;

  // One clock cycle: drive the bus response, sample mid-cycle, update model.
  task automatic step();
    if (bq.size() > 0 && bq[0].due <= cyc) begin
      ibus_rvalid = 1'b1;
      ibus_rdata  = mem_word(bq[0].addr);
    end else begin
      ibus_rvalid = 1'b0;
      ibus_rdata  = $urandom;
    end
    @(negedge clk);
    obs_req    = ibus_req;
    obs_valid  = if_valid;
    obs_rvalid = ibus_rvalid;
    obs_pc     = if_pc;
    obs_addr   = ibus_addr;

    if (redirect_valid) check("req_during_redirect", 32'(ibus_req), 32'd0);
    if (halted)         check("req_while_halted", 32'(ibus_req), 32'd0);
    if (!if_valid)      check("empty_instr_nop", if_instr, NOP);

    if (ibus_req && ibus_ready) begin
      check("req_addr", ibus_addr, exp_req_pc);
      exp_req_pc += 32'd4;
      hs_count++;
      hs_log.push_back(ibus_addr);
      bq.push_back('{addr: ibus_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    end

    if (if_valid && id_ready && !redirect_valid) begin
      check("pop_pc", if_pc, exp_pc);
      check("pop_instr", if_instr, exp_exc ? NOP : mem_word(exp_pc));
      check("pop_exc", 32'(exc_instr_misalign), 32'(exp_exc));
      $display("pop pc=%08h instr=%08h exc=%0d cyc=%0d", if_pc, if_instr, exc_instr_misalign, cyc);
      if (first_pending) begin
        first_pending   = 1'b0;
        first_pop_pc    = if_pc;
        first_pop_instr = if_instr;
        first_pop_exc   = exc_instr_misalign;
      end
      exp_pc += 32'd4;
      pop_count++;
      total_pops++;
    end

    if (ibus_rvalid) bq.delete(0);
    check("outstanding_bound", 32'(bq.size() <= DEPTH), 32'd1);

    if (redirect_valid) begin
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
      exp_pc  = redirect_pc;
      exp_exc = (redirect_pc[1:0] != 2'b00);
      halted  = exp_exc;
`else
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
      exp_exc = 1'b0;
`endif
      exp_req_pc    = redirect_pc & 32'hFFFF_FFFC;
      first_pending = 1'b1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_b          = 1'b0;
    redirect_valid = 1'b0;
    ibus_ready     = 1'b0;
    id_ready       = 1'b0;
    ibus_rvalid    = 1'b0;
    bq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ibus_req", 32'(ibus_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_exc", 32'(exc_instr_misalign), 32'd0);
    @(posedge clk);
    #1;
    rst_b         = 1'b1;
    cyc           = 0;
    exp_pc        = 32'd0;
    exp_req_pc    = 32'd0;
    exp_exc       = 1'b0;
    halted        = 1'b0;
    hs_count      = 0;
    pop_count     = 0;
    first_pending = 1'b1;
    first_pop_pc  = 32'hDEAD_DEAD;
    hs_log.delete();
  endtask

  task automatic redirect_step(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int hs_before;

    // --- Streaming, 1-cycle response, decode always ready -------------------
    // With two entries of reservation, an entry being popped still counts, so
    // requests issue two out of every three cycles in steady state.
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
    step(); check("t1_req_c1", 32'(obs_req), 32'd1); check("t1_valid_c1", 32'(obs_valid), 32'd0);
    step(); check("t1_req_c2", 32'(obs_req), 32'd1); check("t1_valid_c2", 32'(obs_valid), 32'd0);
    step(); check("t1_valid_c3", 32'(obs_valid), 32'd1); check("t1_pc_c3", obs_pc, 32'h0);
            check("t1_req_c3", 32'(obs_req), 32'd0);
    step(); check("t1_valid_c4", 32'(obs_valid), 32'd1); check("t1_pc_c4", obs_pc, 32'h4);
            check("t1_req_c4", 32'(obs_req), 32'd1);
    step(); check("t1_valid_c5", 32'(obs_valid), 32'd0); check("t1_hold_pc_c5", obs_pc, 32'h4);
    step(); check("t1_valid_c6", 32'(obs_valid), 32'd1); check("t1_pc_c6", obs_pc, 32'h8);
    check("t1_addr0", hs_log[0], 32'h0);
    check("t1_addr1", hs_log[1], 32'h4);
    check("t1_addr2", hs_log[2], 32'h8);

    // --- Decode stall fills the buffer, then requests stop -------------------
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b0; lat_min = 1; lat_max = 1;
    repeat (10) step();
    check("t2_req_count", 32'(hs_count), 32'd2);
    check("t2_req_low", 32'(obs_req), 32'd0);
    check("t2_valid", 32'(obs_valid), 32'd1);
    check("t2_head_pc", obs_pc, 32'h0);
    id_ready = 1'b1;
    repeat (8) step();
    check("t2_resume", 32'(pop_count >= 3), 32'd1);

    // --- Redirect with two stale reads in flight (3-cycle latency) -----------
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b1; lat_min = 3; lat_max = 3;
    step(); step();
    check("t3_in_flight", 32'(bq.size()), 32'd2);
    redirect_step(32'h0000_0100);
    repeat (12) step();
    check("t3_first_pc", first_pop_pc, 32'h0000_0100);
    check("t3_first_instr", first_pop_instr, mem_word(32'h0000_0100));

    // --- Redirect coinciding with a response and a decode pop ----------------
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
    step(); step();
    redirect_step(32'h0000_0200);
    check("t4_rvalid_same", 32'(obs_rvalid), 32'd1);
    check("t4_valid_same", 32'(obs_valid), 32'd1);
    step();
    check("t4_req_next", 32'(obs_req), 32'd1);
    check("t4_addr_next", obs_addr, 32'h0000_0200);
    repeat (4) step();
    check("t4_first_pc", first_pop_pc, 32'h0000_0200);

    // --- PC wrap-around ------------------------------------------------------
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
    redirect_step(32'hFFFF_FFF8);
    repeat (8) step();
    check("t5_req_count", 32'(hs_log.size() >= 3), 32'd1);
    if (hs_log.size() >= 3) begin
      check("t5_addr0", hs_log[0], 32'hFFFF_FFF8);
      check("t5_addr1", hs_log[1], 32'hFFFF_FFFC);
      check("t5_addr2", hs_log[2], 32'h0000_0000);
    end
    check("t5_first_pc", first_pop_pc, 32'hFFFF_FFF8);

    // --- Misaligned redirect target ------------------------------------------
    do_reset();
    ibus_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
    step();
    hs_before = hs_count;
    redirect_step(32'h0000_0102);
    repeat (10) step();
`ifdef INSTR_FETCH_MISALIGN_EXC_EN
    check("t6_first_pc", first_pop_pc, 32'h0000_0102);
    check("t6_first_instr", first_pop_instr, NOP);
    check("t6_first_exc", 32'(first_pop_exc), 32'd1);
    check("t6_no_fetch", 32'(hs_count - hs_before), 32'd0);
`else
    check("t6_first_pc", first_pop_pc, 32'h0000_0100);
    check("t6_first_instr", first_pop_instr, mem_word(32'h0000_0100));
    check("t6_first_exc", 32'(first_pop_exc), 32'd0);
    check("t6_fetched", 32'(hs_count > hs_before), 32'd1);
`endif
    redirect_step(32'h0000_0300);
    repeat (8) step();
    check("t6_resume_pc", first_pop_pc, 32'h0000_0300);

    // --- Randomised traffic with redirects and a reset mid-run ---------------
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      ibus_ready = ($urandom_range(0, 99) < 75);
      id_ready   = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        if ($urandom_range(0, 4) != 0) redirect_pc[1:0] = 2'b00;
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    check("rand_progress", 32'(total_pops > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
